register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL provide parameter BYPASS_EN, default 1, enabling write-to-read forwarding within the same cycle.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port write_address  input  `GPR_SIZE  destination register, driven by the write-back stage.
REQ-005 SHALL provide port write_data  input  `DATA_SIZE  value to store.
REQ-006 SHALL provide port write_enable  input  1  commit write_data to write_address at the next edge.
REQ-007 SHALL provide ports read_address_a and read_address_b  input  `GPR_SIZE  each  operand source registers.
REQ-008 SHALL provide ports read_data_a and read_data_b  output  `DATA_SIZE  each  operand values.
REQ-009 SHALL provide port reserve_address  input  `GPR_SIZE  destination of the instruction being issued.
REQ-010 SHALL provide port reserve_enable  input  1  mark reserve_address pending at the next edge.
REQ-011 SHALL provide port hazard  output  1  high when either read port addresses a pending register that is not being written this cycle.

Function
REQ-012 SHALL hold 2^`GPR_SIZE registers of `DATA_SIZE bits, all writable, with no hard-wired zero register.
REQ-013 SHALL write write_data into register write_address on the rising edge when write_enable=1; no other register changes.
REQ-014 SHALL drive read_data_a/b combinationally from the addressed register (zero-cycle read latency).
REQ-015 SHALL, when BYPASS_EN=1, write_enable=1 and read_address_x==write_address, drive read_data_x=write_data in that same cycle.
REQ-016 SHALL, when BYPASS_EN=0, return the pre-write register value in the write cycle and the new value from the next cycle.
REQ-017 SHALL keep one pending bit per register (scoreboard).
REQ-018 SHALL set pending[reserve_address] on the edge when reserve_enable=1.
REQ-019 SHALL clear pending[write_address] on the edge when write_enable=1.
REQ-020 SHALL, when reserve and write target the same register in the same cycle, leave pending set (the newer reservation wins) while still storing write_data.
REQ-021 SHALL, when reserve and write target different registers in the same cycle, apply both updates.
REQ-022 SHALL compute hazard combinationally as (pending[read_address_a] and not write match on a) or (pending[read_address_b] and not write match on b); the write-match exemption applies only when BYPASS_EN=1.
REQ-023 SHALL ignore reserve_enable for the hazard of the current cycle; a reservation takes effect from the next cycle.
REQ-024 SHALL tolerate read_address_a==read_address_b, returning identical data and hazard contribution.

Reset
REQ-025 SHALL, on an edge with reset=1, clear all registers to zero and all pending bits to zero, overriding any simultaneous write or reserve.
REQ-026 SHALL drive hazard=0 and read_data_a/b=0 in the cycle after reset for any addresses, provided no write is presented in that cycle.
REQ-027 SHALL discard an in-flight reservation when reset is asserted mid-operation; no later write-back is required to clear it.

Structure
REQ-028 SHALL take `GPR_SIZE and `DATA_SIZE from architecture.vh; the register count derives from `GPR_SIZE and SHALL NOT be a local constant.
REQ-029 SHALL be a single module; the scoreboard MAY be factored into sub-module register_scoreboard (reserve/clear/query logic only).
REQ-030 SHALL connect directly to the write-back unit outputs with no glue logic.

Verification
REQ-031 After reset: read R3 and R5 -> read_data_a=0, read_data_b=0, hazard=0.
REQ-032 Write R2=0x00AB; next cycle read_a=R2 -> 0x00AB. With BYPASS_EN=1, reading R2 in the write cycle -> 0x00AB; with BYPASS_EN=0 -> 0 in that cycle, 0x00AB the next.
REQ-033 Reserve R4; next cycle read_b=R4 -> hazard=1. Write R4=0x0011 -> hazard=0 in that cycle (BYPASS_EN=1) and read_data_b=0x0011.
REQ-034 Same cycle: reserve R6 and write R6=0x0022 -> R6 holds 0x0022, and pending[R6] stays set (read R6 next cycle -> hazard=1).
REQ-035 Reserve R1, then assert reset before any write -> after reset, read R1 -> hazard=0, data 0.
REQ-036 Random writes to all registers checked against a reference array for 1000 cycles -> no mismatch; hazard matches the model scoreboard every cycle.

Source files
------------

// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
// Shared widths and sizes for the register file and its scoreboard.
// GPR_SIZE / DATA_SIZE normally come from architecture.vh; the guarded
// defaults below let the block elaborate on its own when that header is not
// part of the compile.
// -----------------------------------------------------------------------------
`ifndef GPR_SIZE
`define GPR_SIZE 5
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package register_file_pkg;
    localparam int GPR_W    = `GPR_SIZE;
    localparam int DATA_W   = `DATA_SIZE;
    // Register count follows the address width, never a fixed constant.
    localparam int NUM_REGS = 1 << GPR_W;

    typedef logic [GPR_W-1:0]  gpr_addr_t;
    typedef logic [DATA_W-1:0] gpr_data_t;

    // True when a write this cycle targets the given read address.
    function automatic logic write_hits(input logic we, input gpr_addr_t wa,
                                        input gpr_addr_t ra);
        return we && (wa == ra);
    endfunction
endpackage

// File: rtl/register_file_scoreboard.sv
// -----------------------------------------------------------------------------
// register_scoreboard
// One pending bit per register. Issue reserves a destination, write-back
// clears it. Two combinational query ports report the pending state.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   reserve_address/_en set pending on next edge
//   clear_address/_en   clear pending on next edge
//   query_a/b_address   lookup addresses
//   pending_a/b         pending state of the looked-up registers
// -----------------------------------------------------------------------------
module register_scoreboard
    import register_file_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  gpr_addr_t reserve_address,
    input  logic      reserve_enable,
    input  gpr_addr_t clear_address,
    input  logic      clear_enable,
    input  gpr_addr_t query_a_address,
    input  gpr_addr_t query_b_address,
    output logic      pending_a,
    output logic      pending_b
);

    logic [NUM_REGS-1:0] pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clear_enable)
            pending_d[clear_address] = 1'b0;
        // Applied after the clear: a same-register reservation is the newer
        // instruction and must stay pending.
        if (reserve_enable)
            pending_d[reserve_address] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pending_q <= '0;
        else
            pending_q <= pending_d;
    end

    assign pending_a = pending_q[query_a_address];
    assign pending_b = pending_q[query_b_address];

endmodule

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 2^GPR_SIZE general-purpose registers, two combinational read ports, one
// write port, optional write-to-read forwarding and a scoreboard-driven
// hazard flag. Port names match the write-back unit so it wires up directly.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   write_address/data/enable      write-back port
//   read_address_a/b, read_data_a/b operand reads (zero latency)
//   reserve_address/enable         mark an issued destination pending
//   hazard                         an operand is pending and not being written
// -----------------------------------------------------------------------------
module register_file
    import register_file_pkg::*;
#(
    parameter int BYPASS_EN = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  gpr_addr_t write_address,
    input  gpr_data_t write_data,
    input  logic      write_enable,
    input  gpr_addr_t read_address_a,
    input  gpr_addr_t read_address_b,
    output gpr_data_t read_data_a,
    output gpr_data_t read_data_b,
    input  gpr_addr_t reserve_address,
    input  logic      reserve_enable,
    output logic      hazard
);

    gpr_data_t regs_q [NUM_REGS];
    gpr_data_t regs_d [NUM_REGS];

    logic fwd_a, fwd_b;
    logic pend_a, pend_b;

    always_comb begin
        regs_d = regs_q;
        if (write_enable)
            regs_d[write_address] = write_data;
    end

    always_ff @(posedge clk) begin
        if (reset)
            regs_q <= '{default: '0};
        else
            regs_q <= regs_d;
    end

    // Forwarding and the hazard exemption both hinge on the same match.
    assign fwd_a = (BYPASS_EN != 0) && write_hits(write_enable, write_address, read_address_a);
    assign fwd_b = (BYPASS_EN != 0) && write_hits(write_enable, write_address, read_address_b);

    assign read_data_a = fwd_a ? write_data : regs_q[read_address_a];
    assign read_data_b = fwd_b ? write_data : regs_q[read_address_b];

    register_scoreboard u_scoreboard (
        .clk             (clk),
        .reset           (reset),
        .reserve_address (reserve_address),
        .reserve_enable  (reserve_enable),
        .clear_address   (write_address),
        .clear_enable    (write_enable),
        .query_a_address (read_address_a),
        .query_b_address (read_address_b),
        .pending_a       (pend_a),
        .pending_b       (pend_b)
    );

    // reserve_enable is deliberately absent: it only affects the next cycle.
    assign hazard = (pend_a && !fwd_a) || (pend_b && !fwd_b);

endmodule

// File: tb/tb_register_file.sv
`ifndef GPR_SIZE
`define GPR_SIZE 5
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module tb_register_file;
    import register_file_pkg::*;

    localparam int NR = 1 << `GPR_SIZE;

    logic      clk = 1'b0;
    logic      reset;
    gpr_addr_t wa, ra, rb, rsa;
    gpr_data_t wd;
    logic      we, re;
    gpr_data_t rda1, rdb1, rda0, rdb0;
    logic      hz1, hz0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_file #(.BYPASS_EN(1)) u_dut (
        .clk(clk), .reset(reset),
        .write_address(wa), .write_data(wd), .write_enable(we),
        .read_address_a(ra), .read_address_b(rb),
        .read_data_a(rda1), .read_data_b(rdb1),
        .reserve_address(rsa), .reserve_enable(re),
        .hazard(hz1)
    );

    register_file #(.BYPASS_EN(0)) u_dut_nb (
        .clk(clk), .reset(reset),
        .write_address(wa), .write_data(wd), .write_enable(we),
        .read_address_a(ra), .read_address_b(rb),
        .read_data_a(rda0), .read_data_b(rdb0),
        .reserve_address(rsa), .reserve_enable(re),
        .hazard(hz0)
    );

    task automatic idle();
        we = 0; re = 0; reset = 0;
        wa = '0; wd = '0; rsa = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        // Reset must override a simultaneous write and reservation.
        reset = 1; we = 1; wa = 5'd3; wd = 32'hDEAD; re = 1; rsa = 5'd5;
        step();
        idle(); ra = 5'd3; rb = 5'd5; #1;
        checks++; if (rda1 !== 0) begin failures++; $display("FAIL reset_rda got=%h exp=0", rda1); end
        checks++; if (rdb1 !== 0) begin failures++; $display("FAIL reset_rdb got=%h exp=0", rdb1); end
        checks++; if (hz1 !== 0)  begin failures++; $display("FAIL reset_hazard got=%b exp=0", hz1); end
        checks++; if (hz0 !== 0 || rda0 !== 0) begin failures++; $display("FAIL reset_nb got hz=%b rda=%h exp 0/0", hz0, rda0); end
    endtask

    task automatic test_write_read();
        we = 1; wa = 5'd2; wd = 32'h00AB; ra = 5'd2; rb = 5'd0; #1;
        checks++; if (rda1 !== 32'h00AB) begin failures++; $display("FAIL bypass_same_cycle got=%h exp=000000ab", rda1); end
        checks++; if (rda0 !== 32'h0)    begin failures++; $display("FAIL nobypass_same_cycle got=%h exp=0", rda0); end
        step();
        idle(); ra = 5'd2; #1;
        checks++; if (rda1 !== 32'h00AB) begin failures++; $display("FAIL write_next_cycle got=%h exp=000000ab", rda1); end
        checks++; if (rda0 !== 32'h00AB) begin failures++; $display("FAIL nobypass_next_cycle got=%h exp=000000ab", rda0); end
    endtask

    task automatic test_reserve_hazard();
        re = 1; rsa = 5'd4; ra = 5'd0; rb = 5'd4; #1;
        checks++; if (hz1 !== 0) begin failures++; $display("FAIL reserve_not_immediate got=%b exp=0", hz1); end
        step();
        idle(); ra = 5'd0; rb = 5'd4; #1;
        checks++; if (hz1 !== 1 || hz0 !== 1) begin failures++; $display("FAIL reserved_hazard got=%b/%b exp=1/1", hz1, hz0); end
        we = 1; wa = 5'd4; wd = 32'h0011; #1;
        checks++; if (hz1 !== 0) begin failures++; $display("FAIL write_exempts_hazard got=%b exp=0", hz1); end
        checks++; if (rdb1 !== 32'h0011) begin failures++; $display("FAIL write_fwd_b got=%h exp=00000011", rdb1); end
        checks++; if (hz0 !== 1 || rdb0 !== 32'h0) begin failures++; $display("FAIL nobypass_no_exempt got hz=%b rdb=%h exp 1/0", hz0, rdb0); end
        step();
        idle(); rb = 5'd4; #1;
        checks++; if (hz1 !== 0 || hz0 !== 0 || rdb0 !== 32'h0011) begin failures++; $display("FAIL pending_cleared got hz=%b/%b rdb0=%h exp 0/0/11", hz1, hz0, rdb0); end
    endtask

    task automatic test_same_cycle();
        re = 1; rsa = 5'd6; we = 1; wa = 5'd6; wd = 32'h0022;
        step();
        idle(); ra = 5'd6; rb = 5'd6; #1;
        checks++; if (hz1 !== 1) begin failures++; $display("FAIL same_reg_pending got=%b exp=1", hz1); end
        checks++; if (rda1 !== 32'h0022 || rdb1 !== 32'h0022) begin failures++; $display("FAIL same_reg_data got=%h/%h exp=22/22", rda1, rdb1); end
        we = 1; wa = 5'd6; wd = 32'h0022;  // retire it
        step();
        idle();
    endtask

    task automatic test_diff_targets();
        re = 1; rsa = 5'd8;
        step();
        idle(); re = 1; rsa = 5'd7; we = 1; wa = 5'd8; wd = 32'h0033;
        step();
        idle(); ra = 5'd7; rb = 5'd8; #1;
        checks++; if (hz1 !== 1) begin failures++; $display("FAIL diff_reserve_applied got=%b exp=1", hz1); end
        checks++; if (rdb1 !== 32'h0033) begin failures++; $display("FAIL diff_write_applied got=%h exp=00000033", rdb1); end
        ra = 5'd8; #1;
        checks++; if (hz1 !== 0) begin failures++; $display("FAIL diff_clear_applied got=%b exp=0", hz1); end
        we = 1; wa = 5'd7; wd = '0;
        step();
        idle();
    endtask

    task automatic test_reset_reservation();
        re = 1; rsa = 5'd1;
        step();
        idle(); ra = 5'd1; rb = 5'd2; #1;
        checks++; if (hz1 !== 1) begin failures++; $display("FAIL inflight_reserved got=%b exp=1", hz1); end
        reset = 1;
        step();
        idle(); ra = 5'd1; rb = 5'd2; #1;
        checks++; if (hz1 !== 0) begin failures++; $display("FAIL reset_discards_reserve got=%b exp=0", hz1); end
        checks++; if (rda1 !== 0 || rdb1 !== 0) begin failures++; $display("FAIL reset_clears_regs got=%h/%h exp=0/0", rda1, rdb1); end
    endtask

    task automatic test_random();
        gpr_data_t mref [NR];
        logic      mpend [NR];
        gpr_data_t ea1, eb1;
        logic      eh1, eh0, ma, mb;
        reset = 1; step(); idle();
        for (int i = 0; i < NR; i++) begin mref[i] = '0; mpend[i] = 1'b0; end
        for (int c = 0; c < 1000; c++) begin
            we  = ($urandom_range(0, 3) != 0);
            wa  = gpr_addr_t'($urandom_range(0, NR-1));
            wd  = $urandom;
            re  = ($urandom_range(0, 2) == 0);
            rsa = gpr_addr_t'($urandom_range(0, NR-1));
            ra  = gpr_addr_t'($urandom_range(0, NR-1));
            rb  = (c % 7 == 0) ? ra : gpr_addr_t'($urandom_range(0, NR-1));
            #1;
            ma  = we && (wa == ra);
            mb  = we && (wa == rb);
            ea1 = ma ? wd : mref[ra];
            eb1 = mb ? wd : mref[rb];
            eh1 = (mpend[ra] && !ma) || (mpend[rb] && !mb);
            eh0 = mpend[ra] || mpend[rb];
            checks++; if (rda1 !== ea1) begin failures++; $display("FAIL rand_rda c=%0d got=%h exp=%h", c, rda1, ea1); end
            checks++; if (rdb1 !== eb1) begin failures++; $display("FAIL rand_rdb c=%0d got=%h exp=%h", c, rdb1, eb1); end
            checks++; if (hz1 !== eh1)  begin failures++; $display("FAIL rand_hazard c=%0d got=%b exp=%b", c, hz1, eh1); end
            checks++; if (rda0 !== mref[ra] || rdb0 !== mref[rb]) begin failures++; $display("FAIL rand_nb_data c=%0d got=%h/%h exp=%h/%h", c, rda0, rdb0, mref[ra], mref[rb]); end
            checks++; if (hz0 !== eh0)  begin failures++; $display("FAIL rand_nb_hazard c=%0d got=%b exp=%b", c, hz0, eh0); end
            step();
            if (we) begin mref[wa] = wd; mpend[wa] = 1'b0; end
            if (re) mpend[rsa] = 1'b1;
        end
        idle();
    endtask

    initial begin
        idle(); ra = '0; rb = '0;
        reset = 1;
        step(); step();
        test_reset();
        test_write_read();
        test_reserve_hazard();
        test_same_cycle();
        test_diff_targets();
        test_reset_reservation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
